uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single console UART transmitter (transmit / tx_byte / is_transmitting handshake) between N byte-stream requesters, e.g. the CPU console path and the boot/debug path.
- Round-robin grant. Each grant is held for a whole packet, so lines from different sources never interleave on txd.
- Sits between the requesters and the uart instance in the Nexys4DDR top.

Parameters:
- N_REQ, 2: number of requesters (2..8).
- LINE_LOCK, 1: when 1, byte 0x0A also ends a packet; when 0, only req_last ends it.
- IDLE_TIMEOUT, 1024: cycles an owner may leave req_valid low in LOAD before its grant is revoked (>=2).
- START_TIMEOUT, 4: cycles to wait for is_transmitting to rise after a transmit pulse before the byte is treated as sent (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  byte is the final byte of its packet
- req_ready  out  N_REQ  byte accepted this cycle (one-hot or zero)
- grant  out  N_REQ  current owner (one-hot or zero)
- uart_transmit  out  1  one-cycle transmit pulse to the uart
- uart_tx_byte  out  8  byte to the uart; stable from pulse until return to LOAD/IDLE
- uart_is_transmitting  in  1  uart busy flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; grant=0, req_ready=0, uart_transmit=0, uart_tx_byte=0, busy=0; rr pointer=0; timers=0.
- Reset mid-frame aborts arbitration only. The uart completes or resets on its own.
- IDLE:
  - If any req_valid: owner = first asserted index searching rr, rr+1, ... mod N_REQ.
  - Register grant (visible next cycle); go LOAD. No data accepted in IDLE.
- LOAD:
  - req_ready[owner] = req_valid[owner], combinational in this state only.
  - On acceptance: latch req_data[owner] into uart_tx_byte; latch end = req_last[owner] | (LINE_LOCK & byte==8'h0A); clear idle timer; go START.
  - Otherwise increment the idle timer. At IDLE_TIMEOUT-1: grant=0, rr=owner+1 mod N_REQ, go IDLE.
- START: uart_transmit=1 for exactly this cycle; clear start timer; go WAIT_HI.
- WAIT_HI:
  - If uart_is_transmitting=1: go WAIT_LO.
  - Else count. At START_TIMEOUT-1, treat the byte as sent and go to the DONE decision.
- WAIT_LO: when uart_is_transmitting=0, go to the DONE decision.
- DONE decision (same cycle, not a separate state):
  - If end: grant=0, rr=owner+1 mod N_REQ, go IDLE.
  - Else go LOAD with grant held.
- Latency:
  - Idle requester valid at cycle t: grant at t+1, req_ready at t+1, uart_transmit at t+2.
  - Back-to-back bytes in one packet: the next req_ready comes one cycle after is_transmitting falls.
- Non-owner req_valid is ignored while an owner holds grant. Such requesters wait; no byte is dropped.
- Simultaneous requests in IDLE: the rr order decides. After a release the releasing requester has lowest priority.
- Owner deasserting valid mid-packet: grant is held until IDLE_TIMEOUT, then revoked. A later byte from that source re-arbitrates.
- N_REQ=1 is legal; rr stays 0.
- Invariants: grant is one-hot or zero. At most one req_ready per cycle. uart_transmit is never asserted in two consecutive cycles.

Test Plan:
- Single byte: req0 sends 0x41 with last=1, uart model busy 10 cycles. Required: grant=01 one cycle after valid; exactly one transmit pulse with tx_byte=0x41; after busy falls, grant=00 and busy=0.
- Packet hold: req0 sends "AB\n" (0x41,0x42,0x0A) while req1 continuously offers 0x31 with last=1. Required: txd order 41,42,0A,31; req1's first req_ready only after req0 releases; rr=1 after the packet.
- Round-robin fairness: both requesters stream single-byte packets (last=1) for 8 bytes. Required: strict alternation starting with req0: 0,1,0,1,...
- Idle timeout: IDLE_TIMEOUT=16; req1 sends 0x55 with last=0 then drops valid. Required: grant revoked exactly 16 cycles after re-entering LOAD; req0 granted next if valid.
- Stuck uart: is_transmitting held 0, START_TIMEOUT=4. Required: arbiter advances 4 cycles after each pulse; all 3 bytes of the packet are pulsed; no deadlock.
- Async reset in WAIT_LO: assert rst mid-byte. Required: grant, req_ready, uart_transmit and busy go 0 without a clock edge; after release, the first request arbitrates from rr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin, packet-atomic sharing of one console UART
//                transmitter between N_REQ byte-stream requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_REQ         = 2,
    parameter int LINE_LOCK     = 1,
    parameter int IDLE_TIMEOUT  = 1024,
    parameter int START_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting,
    output logic                 busy
);

    localparam int c_iw      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_idle_w  = $clog2(IDLE_TIMEOUT);
    localparam int c_start_w = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [c_idle_w-1:0]  c_idle_last  = c_idle_w'(IDLE_TIMEOUT - 1);
    localparam logic [c_start_w-1:0] c_start_last = c_start_w'(START_TIMEOUT - 1);
    localparam logic [c_iw-1:0]      c_last_idx   = c_iw'(N_REQ - 1);
    localparam logic [c_iw:0]        c_n_ext      = (c_iw + 1)'(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_REQ-1:0]       r_grant;
    logic [c_iw-1:0]        r_owner;
    logic [c_iw-1:0]        r_rr;
    logic [c_idle_w-1:0]    r_idle_cnt;
    logic [c_start_w-1:0]   r_start_cnt;
    logic [7:0]             r_tx_byte;
    logic                   r_end;

    logic [N_REQ-1:0]       w_rot;
    logic [c_iw-1:0]        w_off;
    logic [c_iw:0]          w_sum;
    logic [c_iw-1:0]        w_pick;
    logic [c_iw-1:0]        w_rr_next;
    logic [7:0]             w_sel_data;
    logic                   w_sel_last;
    logic                   w_accept;
    logic                   w_release;
    logic                   w_done;

    // Rotate the request vector so bit 0 is the rr position; the lowest set
    // bit of the rotated vector is the winner's distance from rr.
    assign w_rot = N_REQ'({req_valid, req_valid} >> r_rr);

    always_comb begin
        w_off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = c_iw'(j);
            end
        end
    end

    assign w_sum     = {1'b0, r_rr} + {1'b0, w_off};
    assign w_pick    = (w_sum >= c_n_ext) ? c_iw'(w_sum - c_n_ext) : c_iw'(w_sum);
    assign w_rr_next = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_sel_data = 8'h00;
        w_sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_sel_data = req_data[i*8 +: 8];
                w_sel_last = req_last[i];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = '0;
        uart_transmit = 1'b0;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                req_ready = r_grant & req_valid;
                if (|(r_grant & req_valid)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end else if (r_idle_cnt == c_idle_last) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                uart_transmit = 1'b1;
                w_state_nxt   = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (uart_is_transmitting) begin
                    w_state_nxt = S_WAIT_LO;
                end else if (r_start_cnt == c_start_last) begin
                    w_done = 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!uart_is_transmitting) begin
                    w_done = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Byte finished: either release the packet or fetch its next byte.
        if (w_done) begin
            if (r_end) begin
                w_release   = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_rr        <= '0;
            r_idle_cnt  <= '0;
            r_start_cnt <= '0;
            r_tx_byte   <= 8'h00;
            r_end       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && (|req_valid)) begin
                r_grant <= N_REQ'(1) << w_pick;
                r_owner <= w_pick;
            end
            if (r_state == S_LOAD && !w_accept && !w_release) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
            if (r_state == S_WAIT_HI) begin
                r_start_cnt <= r_start_cnt + 1'b1;
            end else begin
                r_start_cnt <= '0;
            end
            if (w_accept) begin
                r_tx_byte <= w_sel_data;
                r_end     <= w_sel_last | ((LINE_LOCK != 0) && (w_sel_data == 8'h0A));
            end
            if (w_release) begin
                r_grant <= '0;
                r_rr    <= w_rr_next;
            end
        end
    end

    assign grant        = r_grant;
    assign uart_tx_byte = r_tx_byte;
    assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter with a UART model
//                and a packet-level round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int c_n  = 2;
    localparam int c_it = 16;
    localparam int c_st = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [c_n-1:0]   req_valid = '0;
    logic [8*c_n-1:0] req_data = '0;
    logic [c_n-1:0]   req_last = '0;
    logic [c_n-1:0]   req_ready;
    logic [c_n-1:0]   grant;
    logic             uart_transmit;
    logic [7:0]       uart_tx_byte;
    logic             uart_is_transmitting;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_len = 5;
    int ucnt = 0;
    bit bad_inv = 1'b0;

    logic [7:0] tx_byte_q[$];
    logic [1:0] tx_own_q[$];
    int         tx_cyc_q[$];
    int         all_cyc_q[$];

    uart_tx_arbiter #(
        .N_REQ(c_n), .LINE_LOCK(1), .IDLE_TIMEOUT(c_it), .START_TIMEOUT(c_st)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_is_transmitting(uart_is_transmitting), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART: busy for busy_len cycles after a pulse; busy_len==0 never raises busy.
    always @(posedge clk) begin
        if (uart_transmit && busy_len > 0) ucnt <= busy_len;
        else if (ucnt > 0)                 ucnt <= ucnt - 1;
    end
    assign uart_is_transmitting = (ucnt != 0);

    always @(negedge clk) begin
        if (uart_transmit) begin
            tx_byte_q.push_back(uart_tx_byte);
            tx_own_q.push_back(grant);
            tx_cyc_q.push_back(cyc);
            all_cyc_q.push_back(cyc);
        end
        if (!$onehot0(grant) || !$onehot0(req_ready) || ((req_ready & ~grant) != '0))
            bad_inv <= 1'b1;
    end

    task automatic clear_log();
        tx_byte_q.delete();
        tx_own_q.delete();
        tx_cyc_q.delete();
    endtask

    task automatic drive_byte(input int r, input logic [7:0] d, input logic l, output int acc);
        req_data[r*8 +: 8] = d;
        req_last[r]        = l;
        req_valid[r]       = 1'b1;
        acc = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL handshake req%0d byte %02h: no req_ready, required within 400 cycles", r, d);
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic send_stream(input int r, input logic [8:0] s[$]);
        int acc;
        foreach (s[i]) drive_byte(r, s[i][7:0], s[i][8], acc);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || ucnt != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: busy=%b after 500 cycles, required 0", busy);
        end
    endtask

    task automatic wait_pulse(output int p);
        int n = 0;
        while (tx_cyc_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_cyc_q.size() == 0) begin
            errors++; p = cyc;
            $display("FAIL pulse_wait: no uart_transmit, required within 100 cycles");
        end else begin
            p = tx_cyc_q[0];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b required 00", grant); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b required 00", req_ready); end
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b required 0", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %02h required 00", uart_tx_byte); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_byte();
        busy_len = 10;
        clear_log();
        @(posedge clk); #1;
        req_data[7:0] = 8'h41; req_last[0] = 1'b1; req_valid[0] = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_grant_t0: got %b required 00", grant); end
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant_t1: got %b required 01", grant); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready_t1: got %b required 01", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (uart_transmit !== 1'b1) begin errors++; $display("FAIL single_pulse_t2: got %b required 1", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'h41) begin errors++; $display("FAIL single_byte: got %02h required 41", uart_tx_byte); end
        wait_idle();
        checks++; if (tx_byte_q.size() != 1) begin errors++; $display("FAIL single_pulse_count: got %0d required 1", tx_byte_q.size()); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release: grant %b required 00", grant); end
    endtask

    task automatic test_packet_hold();
        logic [7:0] eb[4] = '{8'h41, 8'h42, 8'h0A, 8'h31};
        logic [1:0] eo[4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        int acc1;
        busy_len = 3;
        clear_log();
        @(posedge clk); #1;
        fork
            send_stream(0, {9'h041, 9'h042, 9'h00A});
            begin
                @(posedge clk); #1;
                drive_byte(1, 8'h31, 1'b1, acc1);
            end
        join
        wait_idle();
        checks++;
        if (tx_byte_q.size() != 4) begin
            errors++; $display("FAIL hold_count: got %0d required 4", tx_byte_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tx_byte_q[i] !== eb[i] || tx_own_q[i] !== eo[i]) begin
                    errors++;
                    $display("FAIL hold_seq[%0d]: got %02h/%b required %02h/%b", i, tx_byte_q[i], tx_own_q[i], eb[i], eo[i]);
                end
            end
            checks++;
            if (acc1 <= tx_cyc_q[2]) begin
                errors++; $display("FAIL hold_req1_ready: cycle %0d required after %0d", acc1, tx_cyc_q[2]);
            end
        end
    endtask

    task automatic test_round_robin();
        busy_len = 2;
        clear_log();
        @(posedge clk); #1;
        fork
            send_stream(0, {9'h130, 9'h132, 9'h134, 9'h136});
            send_stream(1, {9'h131, 9'h133, 9'h135, 9'h137});
        join
        wait_idle();
        checks++;
        if (tx_own_q.size() != 8) begin
            errors++; $display("FAIL rr_count: got %0d required 8", tx_own_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                logic [1:0] e;
                e = (i % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if (tx_own_q[i] !== e || tx_byte_q[i] !== 8'(8'h30 + i)) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %b/%02h required %b/%02h", i, tx_own_q[i], tx_byte_q[i], e, 8'(8'h30 + i));
                end
            end
        end
    endtask

    task automatic test_idle_timeout();
        int acc, p, e;
        busy_len = 3;
        clear_log();
        @(posedge clk); #1;
        drive_byte(1, 8'h55, 1'b0, acc);
        req_data[7:0] = 8'h66; req_last[0] = 1'b1; req_valid[0] = 1'b1;
        wait_pulse(p);
        e = p + busy_len + 2;
        while (cyc < e + 15) @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL timeout_held: grant %b at LOAD+15 required 10", grant); end
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL timeout_revoke: grant %b at LOAD+16 required 00", grant); end
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL timeout_next: grant %b required 01", grant); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL timeout_next_ready: got %b required 01", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_idle();
    endtask

    task automatic test_stuck_uart();
        busy_len = 0;
        clear_log();
        @(posedge clk); #1;
        send_stream(0, {9'h011, 9'h022, 9'h133});
        wait_idle();
        checks++;
        if (tx_byte_q.size() != 3) begin
            errors++; $display("FAIL stuck_count: got %0d required 3", tx_byte_q.size());
        end else begin
            checks++;
            if (tx_byte_q[0] !== 8'h11 || tx_byte_q[1] !== 8'h22 || tx_byte_q[2] !== 8'h33) begin
                errors++; $display("FAIL stuck_bytes: got %02h %02h %02h required 11 22 33", tx_byte_q[0], tx_byte_q[1], tx_byte_q[2]);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (tx_cyc_q[i] - tx_cyc_q[i-1] != c_st + 2) begin
                    errors++; $display("FAIL stuck_spacing[%0d]: got %0d required %0d", i, tx_cyc_q[i] - tx_cyc_q[i-1], c_st + 2);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int acc, p, n;
        busy_len = 10;
        clear_log();
        @(posedge clk); #1;
        drive_byte(1, 8'h77, 1'b0, acc);
        wait_pulse(p);
        while (cyc < p + 4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b required 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00 || req_ready !== 2'b00 || uart_transmit !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: grant=%b ready=%b transmit=%b busy=%b required all 0", grant, req_ready, uart_transmit, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (ucnt != 0 && n < 50) begin @(negedge clk); n++; end
        clear_log();
        @(posedge clk); #1;
        fork
            drive_byte(0, 8'hA0, 1'b1, acc);
            begin int a2; drive_byte(1, 8'hA1, 1'b1, a2); end
        join
        wait_idle();
        checks++;
        if (tx_own_q.size() != 2 || tx_own_q[0] !== 2'b01 || tx_own_q[1] !== 2'b10) begin
            errors++;
            $display("FAIL areset_rr: %0d pulses, first owner %b, required 2 pulses owners 01 then 10",
                     tx_own_q.size(), (tx_own_q.size() > 0) ? tx_own_q[0] : 2'bxx);
        end
    endtask

    // Reference: whole packets granted in round-robin order from a fresh reset.
    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            logic [8:0] s0[$];
            logic [8:0] s1[$];
            logic [7:0] exp_b[$];
            logic [1:0] exp_o[$];
            logic [8:0] w;
            int p0, p1, rr, own, l0, l1;
            l0 = $urandom_range(2, 6);
            l1 = $urandom_range(2, 6);
            for (int i = 0; i < l0; i++) begin
                w[7:0] = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
                w[8]   = (i == l0 - 1) || ($urandom_range(0, 2) == 0);
                s0.push_back(w);
            end
            for (int i = 0; i < l1; i++) begin
                w[7:0] = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
                w[8]   = (i == l1 - 1) || ($urandom_range(0, 2) == 0);
                s1.push_back(w);
            end
            p0 = 0; p1 = 0; rr = 0;
            while (p0 < l0 || p1 < l1) begin
                own = -1;
                for (int k = 0; k < 2; k++) begin
                    int c;
                    c = (rr + k) % 2;
                    if (own < 0 && ((c == 0 && p0 < l0) || (c == 1 && p1 < l1))) own = c;
                end
                do begin
                    if (own == 0) begin w = s0[p0]; p0++; end
                    else          begin w = s1[p1]; p1++; end
                    exp_b.push_back(w[7:0]);
                    exp_o.push_back((own == 0) ? 2'b01 : 2'b10);
                end while (!(w[8] || w[7:0] == 8'h0A));
                rr = (own + 1) % 2;
            end
            busy_len = $urandom_range(0, 6);
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            clear_log();
            @(posedge clk); #1;
            fork
                send_stream(0, s0);
                send_stream(1, s1);
            join
            wait_idle();
            checks++;
            if (tx_byte_q.size() != exp_b.size()) begin
                errors++;
                $display("FAIL random_count round %0d: got %0d required %0d", round, tx_byte_q.size(), exp_b.size());
            end else begin
                for (int i = 0; i < exp_b.size(); i++) begin
                    checks++;
                    if (tx_byte_q[i] !== exp_b[i] || tx_own_q[i] !== exp_o[i]) begin
                        errors++;
                        $display("FAIL random_seq round %0d [%0d]: got %02h/%b required %02h/%b",
                                 round, i, tx_byte_q[i], tx_own_q[i], exp_b[i], exp_o[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_invariants();
        int bad_pairs = 0;
        for (int i = 1; i < all_cyc_q.size(); i++)
            if (all_cyc_q[i] - all_cyc_q[i-1] < 2) bad_pairs++;
        checks++; if (bad_pairs != 0) begin errors++; $display("FAIL inv_transmit_gap: %0d consecutive pulses, required 0", bad_pairs); end
        checks++; if (bad_inv !== 1'b0) begin errors++; $display("FAIL inv_onehot: flag %b required 0", bad_inv); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_packet_hold();
        test_round_robin();
        test_idle_timeout();
        test_stuck_uart();
        test_async_reset();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
